// File: rtl/hazard_unit_mc_if.sv
// Pipeline hazard bus between the core datapath (master) and hazard_unit_mc (slave).
// Carries forwarding sources, operand ids, redirect requests, mul/div handshake and control outputs.
interface hazard_unit_mc_if #(
    parameter int NUM_FWD = 2,
    parameter int XLEN    = 32
);
    logic [NUM_FWD-1:0][4:0]      fwd_rd;
    logic [NUM_FWD-1:0]           fwd_we;
    logic [NUM_FWD-1:0][XLEN-1:0] fwd_wdata;
    logic [4:0]                   rf_rs1_ex;
    logic [4:0]                   rf_rs2_ex;
    logic                         forward1_en;
    logic                         forward2_en;
    logic [XLEN-1:0]              forward1_data;
    logic [XLEN-1:0]              forward2_data;
    logic                         is_load_ex;
    logic [4:0]                   rf_rd_ex;
    logic [4:0]                   rf_rs1_id;
    logic [4:0]                   rf_rs2_id;
    logic                         jump;
    logic [XLEN-1:0]              jump_target;
    logic                         trap;
    logic [XLEN-1:0]              trap_target;
    logic                         md_start;
    logic                         md_done;
    logic                         pc_set;
    logic [XLEN-1:0]              pc_set_target;
    logic [4:0]                   flush;
    logic [5:0]                   stall;

    modport master (
        output fwd_rd, fwd_we, fwd_wdata, rf_rs1_ex, rf_rs2_ex, is_load_ex, rf_rd_ex,
               rf_rs1_id, rf_rs2_id, jump, jump_target, trap, trap_target, md_start, md_done,
        input  forward1_en, forward2_en, forward1_data, forward2_data,
               pc_set, pc_set_target, flush, stall
    );

    modport slave (
        input  fwd_rd, fwd_we, fwd_wdata, rf_rs1_ex, rf_rs2_ex, is_load_ex, rf_rd_ex,
               rf_rs1_id, rf_rs2_id, jump, jump_target, trap, trap_target, md_start, md_done,
        output forward1_en, forward2_en, forward1_data, forward2_data,
               pc_set, pc_set_target, flush, stall
    );
endinterface

// File: rtl/hazard_unit_mc.sv
// Hazard unit for a multi-stage RISC-V pipeline: operand forwarding, load-use stall, redirect flush.
// Define HAZARD_MULDIV_EN to enable the multi-cycle mul/div stall (MD_WAIT); otherwise md_start/md_done are ignored.
module hazard_unit_mc #(
    parameter int NUM_FWD  = 2,
    parameter int LOAD_LAT = 1,
    parameter int XLEN     = 32
) (
    input  logic             clk,
    input  logic             rst,
    hazard_unit_mc_if.slave  hz
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LU_WAIT = 2'd1,
        MD_WAIT = 2'd2
    } state_e;

    // Remaining LU_WAIT cycles after the detecting cycle itself.
    localparam logic [2:0] LU_INIT = 3'(LOAD_LAT - 1);

    state_e          state_r;
    state_e          state_s;
    logic [2:0]      cnt_r;
    logic [2:0]      cnt_s;
    logic            load_use_s;
    logic            redirect_s;
    logic            md_start_s;
    logic            md_done_s;
    logic            fwd1_en_s;
    logic            fwd2_en_s;
    logic [XLEN-1:0] fwd1_data_s;
    logic [XLEN-1:0] fwd2_data_s;
    logic [5:0]      stall_s;
    logic [4:0]      flush_s;
    logic            pc_set_s;

    function automatic logic fwd_hit(input logic we, input logic [4:0] rd, input logic [4:0] rs);
        return we && (rd != 5'd0) && (rd == rs);
    endfunction

`ifdef HAZARD_MULDIV_EN
    assign md_start_s = hz.md_start;
    assign md_done_s  = hz.md_done;
`else
    // Ports stay on the interface but fold to constant zero, leaving MD_WAIT unreachable.
    assign md_start_s = hz.md_start & 1'b0;
    assign md_done_s  = hz.md_done & 1'b0;
`endif

    assign load_use_s = hz.is_load_ex && (hz.rf_rd_ex != 5'd0) &&
                        ((hz.rf_rd_ex == hz.rf_rs1_id) || (hz.rf_rd_ex == hz.rf_rs2_id));
    assign redirect_s = hz.trap | hz.jump;

    // Forwarding mux: scan from oldest to youngest so the lowest matching index wins.
    always_comb begin
        fwd1_en_s   = 1'b0;
        fwd2_en_s   = 1'b0;
        fwd1_data_s = {XLEN{1'b0}};
        fwd2_data_s = {XLEN{1'b0}};
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            fwd1_en_s   = fwd_hit(hz.fwd_we[i], hz.fwd_rd[i], hz.rf_rs1_ex) ? 1'b1 : fwd1_en_s;
            fwd1_data_s = fwd_hit(hz.fwd_we[i], hz.fwd_rd[i], hz.rf_rs1_ex) ? hz.fwd_wdata[i] : fwd1_data_s;
            fwd2_en_s   = fwd_hit(hz.fwd_we[i], hz.fwd_rd[i], hz.rf_rs2_ex) ? 1'b1 : fwd2_en_s;
            fwd2_data_s = fwd_hit(hz.fwd_we[i], hz.fwd_rd[i], hz.rf_rs2_ex) ? hz.fwd_wdata[i] : fwd2_data_s;
        end
    end

    // Control outputs and next-state decision; outputs react in the same cycle as the hazard.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        stall_s  = 6'b000000;
        flush_s  = 5'b00000;
        pc_set_s = 1'b0;
        if (rst) begin
            state_s = RUN;
            cnt_s   = 3'd0;
        end else begin
            case (state_r)
                RUN: begin
                    if (redirect_s) begin
                        pc_set_s = 1'b1;
                        flush_s  = 5'b00111;
                    end else if (md_start_s) begin
                        // A coincident load-use is dropped here and seen again once MD_WAIT exits.
                        state_s = MD_WAIT;
                    end else if (load_use_s) begin
                        stall_s = 6'b000111;
                        flush_s = 5'b00100;
                        if (LOAD_LAT > 1) begin
                            state_s = LU_WAIT;
                            cnt_s   = LU_INIT;
                        end else begin
                            state_s = RUN;
                        end
                    end else begin
                        state_s = RUN;
                    end
                end
                LU_WAIT: begin
                    if (redirect_s) begin
                        pc_set_s = 1'b1;
                        flush_s  = 5'b00111;
                        state_s  = RUN;
                        cnt_s    = 3'd0;
                    end else begin
                        stall_s = 6'b000111;
                        flush_s = 5'b00100;
                        cnt_s   = cnt_r - 3'd1;
                        state_s = (cnt_r == 3'd1) ? RUN : LU_WAIT;
                    end
                end
                MD_WAIT: begin
                    if (redirect_s) begin
                        pc_set_s = 1'b1;
                        flush_s  = 5'b01111;
                        state_s  = RUN;
                    end else if (md_done_s) begin
                        state_s = RUN;
                    end else begin
                        stall_s = 6'b001111;
                        flush_s = 5'b01000;
                    end
                end
                default: begin
                    state_s = RUN;
                    cnt_s   = 3'd0;
                end
            endcase
        end
    end

    // State and load-use counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= RUN;
            cnt_r   <= 3'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    assign hz.forward1_en   = fwd1_en_s;
    assign hz.forward2_en   = fwd2_en_s;
    assign hz.forward1_data = fwd1_data_s;
    assign hz.forward2_data = fwd2_data_s;
    assign hz.stall         = stall_s;
    assign hz.flush         = flush_s;
    assign hz.pc_set        = pc_set_s;
    assign hz.pc_set_target = hz.trap ? hz.trap_target : hz.jump_target;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Self-checking bench for hazard_unit_mc: two instances (LOAD_LAT=2 and 4) share stimulus and are
// compared every cycle against a behavioural model; mul/div scenarios need HAZARD_MULDIV_EN.
module tb_hazard_unit_mc;
    localparam int NF = 2;
    localparam int XL = 32;
`ifdef HAZARD_MULDIV_EN
    localparam bit MD_ON = 1'b1;
`else
    localparam bit MD_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NF-1:0][4:0]    fwd_rd;
    logic [NF-1:0]         fwd_we;
    logic [NF-1:0][XL-1:0] fwd_wdata;
    logic [4:0]            rs1_ex, rs2_ex, rd_ex, rs1_id, rs2_id;
    logic                  is_load, jump, trap, md_start, md_done;
    logic [XL-1:0]         jump_target, trap_target;

    hazard_unit_mc_if #(.NUM_FWD(NF), .XLEN(XL)) h2 ();
    hazard_unit_mc_if #(.NUM_FWD(NF), .XLEN(XL)) h4 ();

    assign h2.fwd_rd = fwd_rd;       assign h2.fwd_we = fwd_we;       assign h2.fwd_wdata = fwd_wdata;
    assign h2.rf_rs1_ex = rs1_ex;    assign h2.rf_rs2_ex = rs2_ex;    assign h2.is_load_ex = is_load;
    assign h2.rf_rd_ex = rd_ex;      assign h2.rf_rs1_id = rs1_id;    assign h2.rf_rs2_id = rs2_id;
    assign h2.jump = jump;           assign h2.jump_target = jump_target;
    assign h2.trap = trap;           assign h2.trap_target = trap_target;
    assign h2.md_start = md_start;   assign h2.md_done = md_done;
    assign h4.fwd_rd = fwd_rd;       assign h4.fwd_we = fwd_we;       assign h4.fwd_wdata = fwd_wdata;
    assign h4.rf_rs1_ex = rs1_ex;    assign h4.rf_rs2_ex = rs2_ex;    assign h4.is_load_ex = is_load;
    assign h4.rf_rd_ex = rd_ex;      assign h4.rf_rs1_id = rs1_id;    assign h4.rf_rs2_id = rs2_id;
    assign h4.jump = jump;           assign h4.jump_target = jump_target;
    assign h4.trap = trap;           assign h4.trap_target = trap_target;
    assign h4.md_start = md_start;   assign h4.md_done = md_done;

    logic [5:0]    st_o [2];
    logic [4:0]    fl_o [2];
    logic          ps_o [2];
    logic [XL-1:0] tg_o [2];
    logic          f1e_o[2], f2e_o[2];
    logic [XL-1:0] f1d_o[2], f2d_o[2];
    assign st_o[0] = h2.stall;  assign fl_o[0] = h2.flush;  assign ps_o[0] = h2.pc_set;  assign tg_o[0] = h2.pc_set_target;
    assign st_o[1] = h4.stall;  assign fl_o[1] = h4.flush;  assign ps_o[1] = h4.pc_set;  assign tg_o[1] = h4.pc_set_target;
    assign f1e_o[0] = h2.forward1_en; assign f1d_o[0] = h2.forward1_data; assign f2e_o[0] = h2.forward2_en; assign f2d_o[0] = h2.forward2_data;
    assign f1e_o[1] = h4.forward1_en; assign f1d_o[1] = h4.forward1_data; assign f2e_o[1] = h4.forward2_en; assign f2d_o[1] = h4.forward2_data;

    hazard_unit_mc #(.NUM_FWD(NF), .LOAD_LAT(2), .XLEN(XL)) dut2 (.clk(clk), .rst(rst), .hz(h2.slave));
    hazard_unit_mc #(.NUM_FWD(NF), .LOAD_LAT(4), .XLEN(XL)) dut4 (.clk(clk), .rst(rst), .hz(h4.slave));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: remaining load-use stall cycles and a mul/div busy flag per instance.
    int lat[2] = '{2, 4};
    int lu_left[2];
    bit md_busy[2];
    int nxt_lu[2];
    bit nxt_md[2];

    task automatic ref_fwd(input logic [4:0] rs, output logic en, output logic [XL-1:0] d);
        en = 1'b0;
        d  = '0;
        for (int i = 0; i < NF; i++) begin
            if (!en && fwd_we[i] && fwd_rd[i] != 5'd0 && fwd_rd[i] == rs) begin
                en = 1'b1;
                d  = fwd_wdata[i];
            end
        end
    endtask

    task automatic sample();
        logic [5:0] es; logic [4:0] ef; logic ep; logic [XL-1:0] et;
        logic e1, e2; logic [XL-1:0] d1, d2;
        bit lu, redir;
        @(negedge clk);
        lu    = is_load && rd_ex != 5'd0 && (rd_ex == rs1_id || rd_ex == rs2_id);
        redir = trap || jump;
        et    = trap ? trap_target : jump_target;
        ref_fwd(rs1_ex, e1, d1);
        ref_fwd(rs2_ex, e2, d2);
        for (int k = 0; k < 2; k++) begin
            es = 6'd0; ef = 5'd0; ep = 1'b0;
            nxt_lu[k] = lu_left[k];
            nxt_md[k] = md_busy[k];
            if (rst) begin
                nxt_lu[k] = 0; nxt_md[k] = 1'b0;
            end else if (md_busy[k]) begin
                if (redir) begin ep = 1'b1; ef = 5'b01111; nxt_md[k] = 1'b0; end
                else if (md_done) nxt_md[k] = 1'b0;
                else begin es = 6'b001111; ef = 5'b01000; end
            end else if (lu_left[k] > 0) begin
                if (redir) begin ep = 1'b1; ef = 5'b00111; nxt_lu[k] = 0; end
                else begin es = 6'b000111; ef = 5'b00100; nxt_lu[k] = lu_left[k] - 1; end
            end else if (redir) begin
                ep = 1'b1; ef = 5'b00111;
            end else if (MD_ON && md_start) begin
                nxt_md[k] = 1'b1;
            end else if (lu) begin
                es = 6'b000111; ef = 5'b00100; nxt_lu[k] = lat[k] - 1;
            end
            chk($sformatf("stall_L%0d", lat[k]),  64'(st_o[k]),  64'(es));
            chk($sformatf("flush_L%0d", lat[k]),  64'(fl_o[k]),  64'(ef));
            chk($sformatf("pc_set_L%0d", lat[k]), 64'(ps_o[k]),  64'(ep));
            chk($sformatf("target_L%0d", lat[k]), 64'(tg_o[k]),  64'(et));
            chk($sformatf("f1en_L%0d", lat[k]),   64'(f1e_o[k]), 64'(e1));
            chk($sformatf("f1d_L%0d", lat[k]),    64'(f1d_o[k]), 64'(d1));
            chk($sformatf("f2en_L%0d", lat[k]),   64'(f2e_o[k]), 64'(e2));
            chk($sformatf("f2d_L%0d", lat[k]),    64'(f2d_o[k]), 64'(d2));
        end
    endtask

    task automatic advance();
        for (int k = 0; k < 2; k++) begin
            lu_left[k] = nxt_lu[k];
            md_busy[k] = nxt_md[k];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        fwd_rd = '0; fwd_we = '0; fwd_wdata = '0;
        rs1_ex = 5'd0; rs2_ex = 5'd0; rd_ex = 5'd0; rs1_id = 5'd0; rs2_id = 5'd0;
        is_load = 1'b0; jump = 1'b0; trap = 1'b0; md_start = 1'b0; md_done = 1'b0;
        jump_target = 32'h0; trap_target = 32'h0;
    endtask

    task automatic idle(input int n);
        clr();
        for (int i = 0; i < n; i++) begin
            sample();
            advance();
        end
    endtask

    initial begin
        rst = 1'b1;
        clr();
        for (int k = 0; k < 2; k++) begin lu_left[k] = 0; md_busy[k] = 1'b0; end
        sample();
        chk("reset_stall", 64'(st_o[0]), 64'd0);
        advance();
        rst = 1'b0;
        idle(2);

        // Load-use with LOAD_LAT=2: two stall cycles then back to RUN.
        is_load = 1'b1; rd_ex = 5'd5; rs1_id = 5'd5;
        sample();
        chk("lu_c1_stall", 64'(st_o[0]), 64'(6'b000111));
        chk("lu_c1_flush", 64'(fl_o[0]), 64'(5'b00100));
        advance();
        clr();
        sample();
        chk("lu_c2_stall", 64'(st_o[0]), 64'(6'b000111));
        chk("lu_c2_flush", 64'(fl_o[0]), 64'(5'b00100));
        advance();
        sample();
        chk("lu_c3_stall", 64'(st_o[0]), 64'd0);
        advance();
        idle(3);

        // Forwarding priority and x0 exclusion.
        fwd_we = 2'b11; fwd_rd[0] = 5'd7; fwd_rd[1] = 5'd7;
        fwd_wdata[0] = 32'hAAAA_0001; fwd_wdata[1] = 32'hBBBB_0002; rs1_ex = 5'd7;
        sample();
        chk("fwd_prio_en", 64'(f1e_o[0]), 64'd1);
        chk("fwd_prio_d",  64'(f1d_o[0]), 64'h0000_0000_AAAA_0001);
        advance();
        fwd_rd[0] = 5'd0; fwd_rd[1] = 5'd0; rs1_ex = 5'd0;
        sample();
        chk("fwd_x0_en", 64'(f1e_o[0]), 64'd0);
        advance();

        // Jump overrides a coincident load-use.
        clr();
        is_load = 1'b1; rd_ex = 5'd3; rs2_id = 5'd3; jump = 1'b1; jump_target = 32'h1000;
        sample();
        chk("jmp_pc_set", 64'(ps_o[0]), 64'd1);
        chk("jmp_target", 64'(tg_o[0]), 64'h1000);
        chk("jmp_flush",  64'(fl_o[0]), 64'(5'b00111));
        chk("jmp_stall",  64'(st_o[0]), 64'd0);
        advance();
        clr();
        sample();
        chk("jmp_after_stall", 64'(st_o[0]), 64'd0);
        advance();

`ifdef HAZARD_MULDIV_EN
        // Mul/div: five stall cycles, released by md_done.
        md_start = 1'b1;
        sample(); advance();
        md_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sample();
            chk("md_stall", 64'(st_o[0]), 64'(6'b001111));
            advance();
        end
        md_done = 1'b1;
        sample();
        chk("md_done_stall", 64'(st_o[0]), 64'd0);
        advance();
        idle(1);
        // Trap while in MD_WAIT.
        md_start = 1'b1;
        sample(); advance();
        md_start = 1'b0;
        sample(); advance();
        trap = 1'b1; trap_target = 32'h80;
        sample();
        chk("md_trap_pc_set", 64'(ps_o[0]), 64'd1);
        chk("md_trap_target", 64'(tg_o[0]), 64'h80);
        chk("md_trap_flush",  64'(fl_o[0]), 64'(5'b01111));
        advance();
        clr();
        sample();
        chk("md_trap_after", 64'(st_o[0]), 64'd0);
        advance();
`endif

        // Async reset in the first LU_WAIT cycle of the LOAD_LAT=4 instance.
        idle(2);
        is_load = 1'b1; rd_ex = 5'd9; rs1_id = 5'd9;
        sample(); advance();
        rst = 1'b1;
        #1;
        chk("arst_stall", 64'(st_o[1]), 64'd0);
        chk("arst_flush", 64'(fl_o[1]), 64'd0);
        chk("arst_pcset", 64'(ps_o[1]), 64'd0);
        for (int k = 0; k < 2; k++) begin lu_left[k] = 0; md_busy[k] = 1'b0; end
        sample(); advance();
        clr();
        rst = 1'b0;
        sample();
        chk("arst_release_stall", 64'(st_o[1]), 64'd0);
        advance();
        idle(3);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NF; i++) begin
                fwd_rd[i] = 5'($urandom_range(0, 3));
                fwd_we[i] = 1'($urandom_range(0, 1));
                fwd_wdata[i] = $urandom;
            end
            rs1_ex = 5'($urandom_range(0, 3)); rs2_ex = 5'($urandom_range(0, 3));
            rd_ex  = 5'($urandom_range(0, 3)); rs1_id = 5'($urandom_range(0, 3));
            rs2_id = 5'($urandom_range(0, 3));
            is_load  = ($urandom_range(0, 9) < 4);
            jump     = ($urandom_range(0, 9) == 0);
            trap     = ($urandom_range(0, 19) == 0);
            md_start = ($urandom_range(0, 9) == 0);
            md_done  = ($urandom_range(0, 3) == 0);
            jump_target = $urandom; trap_target = $urandom;
            sample();
            advance();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
